// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port synchronous data RAM between the CPU memory
// stage (port c) and a debug/loader master (port d) with round-robin arbitration.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   output logic [DATA_WIDTH-1:0] c_rdata,
   output logic                  c_ack,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ack,
   output logic                  ram_write_enable,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic {PORT_C = 1'b0, PORT_D = 1'b1} port_t;

   state_t state;
   port_t  last_grant;
   port_t  owner;
   logic   owner_we;
   port_t  winner;

   // A lone requester wins; on a tie the port that was not served last wins.
   // NOTE: always_comb assigns a default before any condition so no latch is inferred.
   always_comb begin
      winner = PORT_C;
      if (d_req && (!c_req || last_grant == PORT_C)) begin
         winner = PORT_D;
      end
   end

   // The RAM port registers are loaded on the grant edge so the RAM sees them
   // during ACCESS; the read data then appears from the RAM during RESP.
   // NOTE: sequential state uses non-blocking assignments so every read in this block sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         last_grant       <= PORT_D;
         owner            <= PORT_C;
         owner_we         <= 1'b0;
         c_rdata          <= '0;
         c_ack            <= 1'b0;
         d_rdata          <= '0;
         d_ack            <= 1'b0;
         ram_write_enable <= 1'b0;
         ram_address      <= '0;
         ram_data_in      <= '0;
         busy             <= 1'b0;
      end else begin
         c_ack <= 1'b0;
         d_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && (c_req || d_req)) begin
                  owner <= winner;
                  if (winner == PORT_D) begin
                     owner_we         <= d_we;
                     ram_write_enable <= d_we;
                     ram_address      <= d_addr;
                     ram_data_in      <= d_wdata;
                  end else begin
                     owner_we         <= c_we;
                     ram_write_enable <= c_we;
                     ram_address      <= c_addr;
                     ram_data_in      <= c_wdata;
                  end
                  busy  <= 1'b1;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               ram_write_enable <= 1'b0;
               state            <= RESP;
            end
            RESP: begin
               if (owner == PORT_D) begin
                  d_ack <= 1'b1;
                  if (!owner_we) begin
                     d_rdata <= ram_data_out;
                  end
               end else begin
                  c_ack <= 1'b1;
                  if (!owner_we) begin
                     c_rdata <= ram_data_out;
                  end
               end
               last_grant <= owner;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-timeline reference model.
module tb_ram_arbiter;

   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int MEM_WORDS = 16;

   logic          clock;
   logic          reset;
   logic          enable;
   logic          c_req, c_we, c_ack;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata, c_rdata;
   logic          d_req, d_we, d_ack;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          ram_write_enable;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in, ram_data_out;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_ack(c_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .ram_write_enable(ram_write_enable), .ram_address(ram_address),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural synchronous RAM with one-cycle read latency.
   logic [DW-1:0] ram_mem [MEM_WORDS];
   always @(posedge clock) begin
      if (ram_write_enable) ram_mem[ram_address[3:0]] <= ram_data_in;
      ram_data_out <= ram_mem[ram_address[3:0]];
   end

   // Reference model: an access granted at edge g occupies edges g..g+2,
   // commits its write at g+1, acks and returns data at g+2.
   logic [DW-1:0] ref_mem [MEM_WORDS];
   int            cyc = 0;
   int            g_cyc = 0;
   logic          g_valid = 1'b0;
   logic          g_d, g_we;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;
   logic          last_d = 1'b1;
   logic          exp_c_ack, exp_d_ack, exp_busy, exp_we;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata, exp_c_rdata, exp_d_rdata;

   function automatic void model_clear();
      exp_c_ack = 1'b0; exp_d_ack = 1'b0; exp_busy = 1'b0; exp_we = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_c_rdata = '0; exp_d_rdata = '0;
      g_valid = 1'b0; last_d = 1'b1;
   endfunction

   function automatic void model_edge();
      cyc++;
      if (g_valid && cyc == g_cyc + 1 && g_we) ref_mem[g_addr[3:0]] = g_wdata;
      if (reset) begin
         model_clear();
         return;
      end
      exp_c_ack = 1'b0;
      exp_d_ack = 1'b0;
      exp_we    = 1'b0;
      if (g_valid && cyc == g_cyc + 2) begin
         if (g_d) begin
            exp_d_ack = 1'b1;
            if (!g_we) exp_d_rdata = ref_mem[g_addr[3:0]];
         end else begin
            exp_c_ack = 1'b1;
            if (!g_we) exp_c_rdata = ref_mem[g_addr[3:0]];
         end
      end
      if ((!g_valid || cyc >= g_cyc + 3) && enable && (c_req || d_req)) begin
         g_d     = d_req && (!c_req || !last_d);
         last_d  = g_d;
         g_valid = 1'b1;
         g_cyc   = cyc;
         g_we    = g_d ? d_we : c_we;
         g_addr  = g_d ? d_addr : c_addr;
         g_wdata = g_d ? d_wdata : c_wdata;
         exp_we    = g_we;
         exp_addr  = g_addr;
         exp_wdata = g_wdata;
      end
      exp_busy = g_valid && (cyc - g_cyc) < 2;
   endfunction

   task automatic tick();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic wait_ack(input logic want_d, input int bound, output logic found, output int cycles);
      found  = 1'b0;
      cycles = 0;
      for (int k = 0; k < bound; k++) begin
         tick();
         cycles++;
         if (want_d ? d_ack : c_ack) begin
            found = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1;
      c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
      c_addr = 32'd5; d_addr = 32'd6; c_wdata = '0; d_wdata = '0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if ({c_ack, d_ack, busy, ram_write_enable, ram_address, ram_data_in, c_rdata, d_rdata} !== '0)
            $display("FAIL reset_outputs: got ack=%b%b busy=%b we=%b addr=%h din=%h crd=%h drd=%h, want all zero",
                     c_ack, d_ack, busy, ram_write_enable, ram_address, ram_data_in, c_rdata, d_rdata);
         else n_pass++;
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b1 || ram_address !== 32'd5)
         $display("FAIL reset_first_grant: got busy=%b addr=%h, want busy=1 addr=5 (cpu)", busy, ram_address);
      else n_pass++;
      tick();
      tick();
      n_checks++;
      if (c_ack !== 1'b1 || d_ack !== 1'b0 || c_rdata !== 32'd0)
         $display("FAIL reset_first_ack: got c_ack=%b d_ack=%b c_rdata=%h, want 1 0 0", c_ack, d_ack, c_rdata);
      else n_pass++;
      c_req = 1'b0;
      begin
         logic found; int cycles;
         wait_ack(1'b1, 6, found, cycles);
         n_checks++;
         if (!found) $display("FAIL reset_second_grant: no d_ack within 6 cycles, want d_ack");
         else n_pass++;
      end
      d_req = 1'b0;
   endtask

   task automatic test_debug_preload();
      logic found; int cycles;
      c_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d_req = 1'b1; d_we = 1'b1; d_addr = AW'(i); d_wdata = DW'(32'h11 * (i + 1));
         wait_ack(1'b1, 6, found, cycles);
         n_checks++;
         if (!found) $display("FAIL preload_ack_%0d: no d_ack within 6 cycles", i);
         else n_pass++;
      end
      d_req = 1'b0; d_we = 1'b0;
      tick();
      n_checks++;
      if (c_rdata !== 32'd0) $display("FAIL preload_c_rdata: got %h, want 0", c_rdata);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (ram_mem[i] !== DW'(32'h11 * (i + 1)))
            $display("FAIL preload_word_%0d: got %h, want %h", i, ram_mem[i], 32'h11 * (i + 1));
         else n_pass++;
      end
      for (int i = 0; i < 5; i++) begin
         c_req = 1'b1; c_we = 1'b0; c_addr = AW'(i);
         wait_ack(1'b0, 6, found, cycles);
         n_checks++;
         if (!found || c_rdata !== DW'(32'h11 * (i + 1)))
            $display("FAIL preload_readback_%0d: found=%b c_rdata=%h, want %h", i, found, c_rdata, 32'h11 * (i + 1));
         else n_pass++;
      end
      c_req = 1'b0;
   endtask

   task automatic test_cpu_write_read();
      logic found; int cycles;
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'd3; c_wdata = 32'hDEADBEEF;
      tick();
      n_checks++;
      if ({ram_write_enable, busy, c_ack} !== 3'b110 || ram_address !== 32'd3 || ram_data_in !== 32'hDEADBEEF)
         $display("FAIL wr_access: got we=%b busy=%b ack=%b addr=%h din=%h, want 1 1 0 3 deadbeef",
                  ram_write_enable, busy, c_ack, ram_address, ram_data_in);
      else n_pass++;
      tick();
      n_checks++;
      if ({ram_write_enable, busy, c_ack} !== 3'b010)
         $display("FAIL wr_resp: got we=%b busy=%b ack=%b, want 0 1 0", ram_write_enable, busy, c_ack);
      else n_pass++;
      tick();
      n_checks++;
      if (c_ack !== 1'b1 || busy !== 1'b0 || c_rdata !== exp_c_rdata)
         $display("FAIL wr_ack: got ack=%b busy=%b c_rdata=%h, want 1 0 %h", c_ack, busy, c_rdata, exp_c_rdata);
      else n_pass++;
      c_we = 1'b0;
      wait_ack(1'b0, 6, found, cycles);
      n_checks++;
      if (!found || cycles != 3 || c_rdata !== 32'hDEADBEEF)
         $display("FAIL rd_ack: found=%b cycles=%0d c_rdata=%h, want 1 3 deadbeef", found, cycles, c_rdata);
      else n_pass++;
      c_req = 1'b0;
      tick();
      n_checks++;
      if (c_ack !== 1'b0 || busy !== 1'b0)
         $display("FAIL rd_ack_single: got ack=%b busy=%b, want 0 0", c_ack, busy);
      else n_pass++;
   endtask

   task automatic test_contention();
      int n_acks = 0;
      logic prev_d = 1'bx;
      c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
      c_addr = 32'd1; d_addr = 32'd2;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (c_ack || d_ack) begin
            n_checks++;
            if ({c_ack, d_ack} !== {exp_c_ack, exp_d_ack} || (c_ack && d_ack) ||
                (n_acks > 0 && d_ack === prev_d) || t != 3 * (n_acks + 1))
               $display("FAIL contention_ack_%0d: got c=%b d=%b at cycle %0d, want c=%b d=%b at cycle %0d alternating",
                        n_acks, c_ack, d_ack, t, exp_c_ack, exp_d_ack, 3 * (n_acks + 1));
            else n_pass++;
            prev_d = d_ack;
            n_acks++;
         end
      end
      c_req = 1'b0; d_req = 1'b0;
      n_checks++;
      if (n_acks != 4) $display("FAIL contention_count: got %0d acks, want 4", n_acks);
      else n_pass++;
      tick();
   endtask

   task automatic test_enable();
      enable = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({d_ack, busy} !== 2'b00) $display("FAIL enable_off_%0d: got ack=%b busy=%b, want 0 0", i, d_ack, busy);
         else n_pass++;
      end
      enable = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b1) $display("FAIL enable_grant: got busy=%b, want 1", busy);
      else n_pass++;
      enable = 1'b0;
      tick();
      tick();
      n_checks++;
      if (d_ack !== 1'b1 || d_rdata !== 32'h33)
         $display("FAIL enable_inflight: got ack=%b d_rdata=%h, want 1 00000033", d_ack, d_rdata);
      else n_pass++;
      d_req = 1'b0; enable = 1'b1;
      tick();
   endtask

   task automatic test_reset_in_resp();
      logic found; int cycles;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd2; d_wdata = 32'h12345678;
      wait_ack(1'b1, 6, found, cycles);
      n_checks++;
      if (!found) $display("FAIL rst_resp_write: no d_ack within 6 cycles");
      else n_pass++;
      d_we = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if ({c_ack, d_ack, busy, ram_write_enable} !== 4'b0 || d_rdata !== 32'd0 || c_rdata !== 32'd0)
         $display("FAIL rst_resp_abort: got ack=%b%b busy=%b we=%b d_rdata=%h c_rdata=%h, want all 0",
                  c_ack, d_ack, busy, ram_write_enable, d_rdata, c_rdata);
      else n_pass++;
      reset = 1'b0;
      wait_ack(1'b1, 6, found, cycles);
      n_checks++;
      if (!found || d_rdata !== 32'h12345678)
         $display("FAIL rst_resp_reread: found=%b d_rdata=%h, want 1 12345678", found, d_rdata);
      else n_pass++;
      d_req = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         tick();
         n_checks++;
         if ({c_ack, d_ack, busy, ram_write_enable} !== {exp_c_ack, exp_d_ack, exp_busy, exp_we})
            $display("FAIL rand_ctrl_%0d: got ack=%b%b busy=%b we=%b, want ack=%b%b busy=%b we=%b", i,
                     c_ack, d_ack, busy, ram_write_enable, exp_c_ack, exp_d_ack, exp_busy, exp_we);
         else n_pass++;
         n_checks++;
         if (ram_address !== exp_addr || ram_data_in !== exp_wdata)
            $display("FAIL rand_ram_bus_%0d: got addr=%h din=%h, want addr=%h din=%h", i,
                     ram_address, ram_data_in, exp_addr, exp_wdata);
         else n_pass++;
         n_checks++;
         if (c_rdata !== exp_c_rdata || d_rdata !== exp_d_rdata)
            $display("FAIL rand_rdata_%0d: got c=%h d=%h, want c=%h d=%h", i,
                     c_rdata, d_rdata, exp_c_rdata, exp_d_rdata);
         else n_pass++;
         if (c_ack) c_req = 1'b0;
         if (d_ack) d_req = 1'b0;
         if (!c_req && $urandom_range(0, 2) == 0) begin
            c_req = 1'b1; c_we = 1'($urandom_range(0, 1)); c_addr = $urandom(); c_wdata = $urandom();
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom(); d_wdata = $urandom();
         end
         enable = ($urandom_range(0, 5) != 0);
      end
      c_req = 1'b0; d_req = 1'b0; enable = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < MEM_WORDS; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end
      model_clear();
      test_reset();
      test_debug_preload();
      test_cpu_write_read();
      test_contention();
      test_enable();
      test_reset_in_resp();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
